// File: rtl/pcie_tlp_pkg.sv
// pcie_tlp_pkg: shared TLP fmt/type constants, completion status codes, completer FSM encoding and captured fields
package pcie_tlp_pkg;
  localparam logic [2:0] FMT_3DW_NODATA = 3'b000;
  localparam logic [2:0] FMT_3DW_DATA = 3'b010;
  localparam logic [4:0] TYPE_CPL = 5'b01010;
  localparam logic [2:0] CPL_SC = 3'b000;
  localparam logic [2:0] CPL_UR = 3'b001;
  localparam logic [2:0] CPL_CA = 3'b100;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CHK = 3'd1;
  localparam logic [2:0] ST_REQ = 3'd2;
  localparam logic [2:0] ST_HDR = 3'd3;
  localparam logic [2:0] ST_DAT = 3'd4;
  typedef struct packed {
    logic with_data;
    logic [9:0] len_dw;
    logic [2:0] status;
    logic [11:0] byte_cnt;
    logic [15:0] req_id;
    logic [7:0] tag;
    logic [6:0] lower_addr;
    logic [7:0] bus_num;
    logic [4:0] dev_num;
    logic [2:0] func_num;
  } cpl_fields_t;
endpackage

// File: rtl/pcie_cpl_hdr_fmt.sv
// pcie_cpl_hdr_fmt: combinational packing of captured completion fields into the three header DWs
module pcie_cpl_hdr_fmt
  import pcie_tlp_pkg::*;
(
  input cpl_fields_t f,
  output logic [31:0] dw0,
  output logic [31:0] dw1,
  output logic [31:0] dw2
);
  always_comb begin
    dw0 = {f.with_data ? FMT_3DW_DATA : FMT_3DW_NODATA, TYPE_CPL, 14'd0, f.with_data ? f.len_dw : 10'd0};
    dw1 = {f.bus_num, f.dev_num, f.func_num, f.status, 1'b0, f.byte_cnt};
    dw2 = {f.req_id, f.tag, 1'b0, f.lower_addr};
  end
endmodule

// File: rtl/pcie_cpl_tx_engine.sv
// pcie_cpl_tx_engine: completion TLP transmit engine, credit check, core handshake, halfword serialiser with underrun nullify
module pcie_cpl_tx_engine
  import pcie_tlp_pkg::*;
#(
  parameter int MAX_LEN_DW = 16
) (
  input logic sys_clk_125,
  input logic rst_n,
  input logic cpl_req,
  output logic cpl_ack,
  input logic cpl_with_data,
  input logic [9:0] cpl_len_dw,
  input logic [2:0] cpl_status,
  input logic [11:0] cpl_byte_cnt,
  input logic [15:0] cpl_req_id,
  input logic [7:0] cpl_tag,
  input logic [6:0] cpl_lower_addr,
  input logic [7:0] bus_num,
  input logic [4:0] dev_num,
  input logic [2:0] func_num,
  input logic [31:0] dat_in,
  input logic dat_vld,
  output logic dat_rd,
  output logic tx_req_vc0,
  input logic tx_rdy_vc0,
  output logic tx_st_vc0,
  output logic tx_end_vc0,
  output logic tx_nlfy_vc0,
  output logic [15:0] tx_data_vc0,
  input logic [8:0] tx_ca_cplh_vc0,
  input logic [12:0] tx_ca_cpld_vc0,
  input logic tx_ca_cpl_recheck_vc0,
  output logic busy,
  output logic err_underrun
);
  localparam logic [9:0] MAX_LEN = 10'(MAX_LEN_DW);
  logic [2:0] state_q, state_d;
  cpl_fields_t fld_q, fld_d, req_f;
  logic [8:0] idx_q, idx_d, last;
  logic [31:0] dat_q, dat_d, dw0, dw1, dw2, hdr_dw;
  logic [15:0] hdr_hw, dat_hw;
  logic [11:0] need;
  logic urun_q, urun_d, ack_q, ack_d, err_q, err_d;
  logic in_tlp, go, dw_due, credit_ok, req_bad;
  pcie_cpl_hdr_fmt u_hdr (.f(fld_q), .dw0(dw0), .dw1(dw1), .dw2(dw2));
  always_comb begin
    req_f = {cpl_with_data, cpl_len_dw, cpl_status, cpl_byte_cnt, cpl_req_id, cpl_tag, cpl_lower_addr, bus_num, dev_num, func_num};
    req_bad = cpl_with_data && (cpl_len_dw == 10'd0 || cpl_len_dw > MAX_LEN);
    last = fld_q.with_data ? 9'd5 + {fld_q.len_dw[7:0], 1'b0} : 9'd5;
    need = ({2'b0, fld_q.len_dw} + 12'd3) >> 2;
    credit_ok = (tx_ca_cplh_vc0[8] || tx_ca_cplh_vc0[7:0] != 8'd0) && (!fld_q.with_data || tx_ca_cpld_vc0[12] || tx_ca_cpld_vc0[11:0] >= need);
    in_tlp = state_q == ST_HDR || state_q == ST_DAT;
    go = in_tlp && tx_rdy_vc0;
    dw_due = in_tlp && fld_q.with_data && idx_q[0] && idx_q >= 9'd5 && idx_q != last && !urun_q;
    hdr_dw = idx_q[2:1] == 2'd0 ? dw0 : idx_q[2:1] == 2'd1 ? dw1 : dw2;
    hdr_hw = idx_q[0] ? hdr_dw[15:0] : hdr_dw[31:16];
    dat_hw = urun_q ? 16'h0 : idx_q[0] ? dat_q[15:0] : dat_q[31:16];
    tx_data_vc0 = state_q == ST_HDR ? hdr_hw : state_q == ST_DAT ? dat_hw : 16'h0;
    tx_req_vc0 = state_q == ST_REQ;
    tx_st_vc0 = state_q == ST_HDR && idx_q == 9'd0;
    tx_end_vc0 = in_tlp && idx_q == last;
    tx_nlfy_vc0 = tx_end_vc0 && urun_q;
    dat_rd = dw_due && dat_vld && tx_rdy_vc0;
    err_underrun = err_q || (tx_nlfy_vc0 && tx_rdy_vc0);
    busy = state_q != ST_IDLE;
    cpl_ack = ack_q;
  end
  always_comb begin
    state_d = state_q;
    fld_d = fld_q;
    idx_d = idx_q;
    dat_d = dat_q;
    urun_d = urun_q;
    ack_d = 1'b0;
    err_d = 1'b0;
    if (state_q == ST_IDLE && cpl_req && !ack_q) begin
      ack_d = 1'b1;
      err_d = req_bad;
      fld_d = req_f;
      idx_d = 9'd0;
      urun_d = 1'b0;
      state_d = req_bad ? ST_IDLE : ST_CHK;
    end
    if (state_q == ST_CHK && credit_ok) state_d = ST_REQ;
    if (state_q == ST_REQ && tx_rdy_vc0) state_d = tx_ca_cpl_recheck_vc0 ? ST_CHK : ST_HDR;
    if (go) begin
      idx_d = idx_q == last ? 9'd0 : idx_q + 9'd1;
      dat_d = dat_rd ? dat_in : dat_q;
      urun_d = urun_q || (dw_due && !dat_vld);
      state_d = idx_q == last ? ST_IDLE : idx_q == 9'd5 ? ST_DAT : state_q;
    end
  end
  always_ff @(posedge sys_clk_125 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      fld_q <= '0;
      idx_q <= '0;
      dat_q <= '0;
      urun_q <= 1'b0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fld_q <= fld_d;
      idx_q <= idx_d;
      dat_q <= dat_d;
      urun_q <= urun_d;
      ack_q <= ack_d;
      err_q <= err_d;
    end
  end
endmodule

// File: doc/pcie_cpl_tx_engine.md
PCIE_CPL_TX_ENGINE -- requirements
Module: pcie_cpl_tx_engine

Interface
REQ-001 Parameter: MAX_LEN_DW, 16, largest accepted completion payload in DWs (range 1..128).
REQ-002 Ports, one clock and one reset; reset is asynchronous and active-low:
- sys_clk_125  in  1  sole clock
- rst_n  in  1  async active-low reset
- cpl_req  in  1  completion request, level, held until cpl_ack
- cpl_ack  out  1  one-cycle pulse: request fields captured
- cpl_with_data  in  1  1 = CplD, 0 = Cpl
- cpl_len_dw  in  10  payload DWs, 1..MAX_LEN_DW, ignored when cpl_with_data=0
- cpl_status  in  3  completion status field
- cpl_byte_cnt  in  12  byte count field
- cpl_req_id  in  16  requester ID
- cpl_tag  in  8  tag
- cpl_lower_addr  in  7  lower address
- bus_num / dev_num / func_num  in  8/5/3  completer ID
- dat_in  in  32  payload DW from first-word-fall-through source
- dat_vld  in  1  dat_in valid
- dat_rd  out  1  pop dat_in this cycle
- tx_req_vc0  out  1  request to transmit
- tx_rdy_vc0  in  1  core grants/accepts data
- tx_st_vc0 / tx_end_vc0  out  1  first/last TLP halfword
- tx_nlfy_vc0  out  1  nullify, valid only with tx_end_vc0
- tx_data_vc0  out  16  TLP halfword
- tx_ca_cplh_vc0  in  9  completion-header credits, bit 8 = infinite
- tx_ca_cpld_vc0  in  13  completion-data credits, bit 12 = infinite
- tx_ca_cpl_recheck_vc0  in  1  credits changed, re-evaluate
- busy  out  1  high in every state except IDLE
- err_underrun  out  1  one-cycle pulse on a nullified TLP

Function
REQ-003 FSM states: IDLE, CHK, REQ, HDR, DAT.
- IDLE -> CHK on cpl_req.
- cpl_ack pulses and all fields register on that transition.
REQ-004 CHK -> REQ when both hold:
- header credits >= 1, or bit 8 set;
- data credits >= ceil(cpl_len_dw/4), or bit 12 set, or cpl_with_data=0.
- Otherwise remain in CHK, re-evaluating every cycle.
REQ-005 REQ: tx_req_vc0=1.
- If tx_rdy_vc0 and tx_ca_cpl_recheck_vc0 are both 1, drop tx_req_vc0 and return to CHK.
- Otherwise, on tx_rdy_vc0=1, drop tx_req_vc0 and enter HDR.
- tx_st_vc0 is high in the next cycle.
REQ-006 HDR drives 6 halfwords, upper half of each DW first:
- DW0: fmt=010 (CplD) or 000 (Cpl); type=01010; TC/attr/TD/EP=0; length=cpl_len_dw (0 for Cpl).
- DW1: {bus,dev,func}, status, BCM=0, byte count.
- DW2: requester ID, tag, 1'b0, lower address.
REQ-007 DAT drives 2 halfwords per DW, upper first. tx_end_vc0 is on the final halfword: the last header halfword for Cpl, or the last data halfword for CplD.
REQ-008 dat_rd pulses in the cycle before each DW's upper halfword is driven, and only when dat_vld=1; dat_in is registered on that pulse.
REQ-009 Underrun (dat_vld=0 when a DW is due):
- drive 0x0000 for all remaining halfwords;
- assert tx_nlfy_vc0 with tx_end_vc0;
- pulse err_underrun on the same cycle;
- issue no further dat_rd for this TLP.
REQ-010 tx_rdy_vc0=0 during HDR/DAT freezes all outputs, the halfword index and dat_rd.
REQ-011 After tx_end_vc0 the FSM returns to IDLE; a pending cpl_req is acked at the earliest one cycle later. Back-to-back TLPs have at least 2 idle cycles between them.
REQ-012 A request with cpl_len_dw=0 or cpl_len_dw>MAX_LEN_DW while cpl_with_data=1 is acked and dropped: no TLP, err_underrun pulses.

Reset
REQ-013 While rst_n=0, regardless of state:
- all outputs are 0: tx_req_vc0, tx_st_vc0, tx_end_vc0, tx_nlfy_vc0, tx_data_vc0, dat_rd, cpl_ack, busy, err_underrun;
- FSM=IDLE;
- captured fields and counters are cleared.
REQ-014 Reset asserted mid-TLP abandons the TLP with no tx_end_vc0. Processing resumes on the first clock edge after rst_n rises.

Structure
REQ-015 The following live in shared package pcie_tlp_pkg:
- fmt/type constants (FMT_3DW_NODATA, FMT_3DW_DATA, TYPE_CPL);
- completion status codes (SC, UR, CA);
- FSM state encoding.
REQ-016 One sub-module, pcie_cpl_hdr_fmt: purely combinational, turns captured fields into 3 DWs. The FSM, counters and handshakes stay in the top module.

Verification
REQ-017 Cpl, bus=0x01, dev=0, func=0, status=UR, byte_cnt=4, req_id=0x0000, tag=0x05, lower_addr=0 -> halfwords 0x0A00,0x0000,0x0100,0x2004,0x0000,0x0500; tx_st on the 1st, tx_end on the 6th.
REQ-018 CplD, len 1, dat_in=0xDEADBEEF -> first halfwords 0x4A00,0x0001; halfwords 7-8 are 0xDEAD,0xBEEF; tx_end on the 8th; exactly one dat_rd.
REQ-019 CplD len 8, cpld credits=1 -> tx_req_vc0 stays 0; credits raised to 2 -> tx_req_vc0 high the following cycle.
REQ-020 tx_ca_cpl_recheck_vc0 high with tx_rdy_vc0 -> no tx_st_vc0; FSM back in CHK; TLP sent intact after the next grant.
REQ-021 CplD len 4, dat_vld drops after 2 DWs -> halfwords 11-14 are 0x0000; tx_nlfy_vc0 and err_underrun on the 14th; 2 dat_rd total.
REQ-022 rst_n low during halfword 3 -> all outputs 0 immediately; a new request after reset produces a full, correct TLP.
